// File: rtl/playfield_writer.sv
// Playfield RAM writer: queues single-write and fill commands and
// drains them into the playfield RAM only while the beam is in vertical blanking.
module playfield_writer #(
    parameter int FIFO_DEPTH = 4,
    parameter int V_ACTIVE   = 480
) (
    input  logic       i_Clk,
    input  logic       i_Reset,
    input  logic [9:0] i_Row,
    input  logic       i_Cmd_Valid,
    output logic       o_Cmd_Ready,
    input  logic       i_Cmd_Op,
    input  logic [9:0] i_Cmd_Addr,
    input  logic [9:0] i_Cmd_Len,
    input  logic [7:0] i_Cmd_Data,
    output logic       o_PF_Write,
    output logic [9:0] o_PF_Addr,
    output logic [7:0] o_PF_Data,
    output logic       o_Busy,
    output logic       o_Done
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam logic [PW:0] FULL = (PW+1)'(FIFO_DEPTH);
    localparam logic [9:0] V_ROW = 10'(V_ACTIVE);

    typedef struct packed {
        logic       op;
        logic [9:0] addr;
        logic [9:0] len;
        logic [7:0] data;
    } cmd_t;

    typedef enum logic {IDLE, EXEC} state_t;

    state_t state, state_next;

    cmd_t          mem [FIFO_DEPTH];
    cmd_t          in_cmd;
    cmd_t          head;
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [PW:0]   count;

    logic [9:0] cur_addr;
    logic [7:0] cur_data;
    logic [9:0] remain;

    logic blank, push, pop, fire, last;

    assign in_cmd      = {i_Cmd_Op, i_Cmd_Addr, i_Cmd_Len, i_Cmd_Data};
    assign head        = mem[rd_ptr];
    assign blank       = (i_Row >= V_ROW);
    assign o_Cmd_Ready = (count < FULL);
    assign push        = i_Cmd_Valid && o_Cmd_Ready;
    assign o_Busy      = (count != '0) || (state == EXEC);

    always_ff @(posedge i_Clk or posedge i_Reset) begin
        if (i_Reset) state <= IDLE;
        else         state <= state_next;
    end

    always_comb begin
        state_next = state;
        pop        = 1'b0;
        fire       = 1'b0;
        last       = 1'b0;
        unique case (state)
            IDLE: begin
                if (count != '0 && blank) begin
                    pop        = 1'b1;
                    state_next = EXEC;
                end
            end
            EXEC: begin
                if (blank) begin
                    fire = 1'b1;
                    if (remain == '0) begin
                        last       = 1'b1;
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Storage is not reset; only pointers and occupancy define validity.
    always_ff @(posedge i_Clk) begin
        if (push) mem[wr_ptr] <= in_cmd;
    end

    always_ff @(posedge i_Clk or posedge i_Reset) begin
        if (i_Reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            unique case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge i_Clk or posedge i_Reset) begin
        if (i_Reset) begin
            cur_addr   <= '0;
            cur_data   <= '0;
            remain     <= '0;
            o_PF_Write <= 1'b0;
            o_PF_Addr  <= '0;
            o_PF_Data  <= '0;
            o_Done     <= 1'b0;
        end else begin
            o_PF_Write <= fire;
            o_Done     <= last;
            if (pop) begin
                cur_addr <= head.addr;
                cur_data <= head.data;
                remain   <= head.op ? head.len : '0;
            end
            if (fire) begin
                o_PF_Addr <= cur_addr;
                o_PF_Data <= cur_data;
                cur_addr  <= cur_addr + 10'd1;
                if (!last) remain <= remain - 10'd1;
            end
        end
    end

endmodule

// File: tb/tb_playfield_writer.sv
// Directed bench for playfield_writer: single write, wrapping fill,
// blanking pause, FIFO backpressure/order and reset mid-fill.
module tb_playfield_writer;

    logic       i_Clk = 1'b0;
    logic       i_Reset = 1'b1;
    logic [9:0] i_Row = 10'd480;
    logic       i_Cmd_Valid = 1'b0;
    logic       o_Cmd_Ready;
    logic       i_Cmd_Op = 1'b0;
    logic [9:0] i_Cmd_Addr = '0;
    logic [9:0] i_Cmd_Len = '0;
    logic [7:0] i_Cmd_Data = '0;
    logic       o_PF_Write;
    logic [9:0] o_PF_Addr;
    logic [7:0] o_PF_Data;
    logic       o_Busy;
    logic       o_Done;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    typedef struct {
        logic [9:0] a;
        logic [7:0] d;
        logic       dn;
        int         t;
    } wr_t;

    wr_t wq[$];

    playfield_writer #(.FIFO_DEPTH(4), .V_ACTIVE(480)) dut (
        .i_Clk      (i_Clk),
        .i_Reset    (i_Reset),
        .i_Row      (i_Row),
        .i_Cmd_Valid(i_Cmd_Valid),
        .o_Cmd_Ready(o_Cmd_Ready),
        .i_Cmd_Op   (i_Cmd_Op),
        .i_Cmd_Addr (i_Cmd_Addr),
        .i_Cmd_Len  (i_Cmd_Len),
        .i_Cmd_Data (i_Cmd_Data),
        .o_PF_Write (o_PF_Write),
        .o_PF_Addr  (o_PF_Addr),
        .o_PF_Data  (o_PF_Data),
        .o_Busy     (o_Busy),
        .o_Done     (o_Done)
    );

    always #5 i_Clk = ~i_Clk;

    always @(posedge i_Clk) cyc <= cyc + 1;

    always @(negedge i_Clk) begin
        if (o_PF_Write === 1'b1) begin
            wr_t w;
            w.a  = o_PF_Addr;
            w.d  = o_PF_Data;
            w.dn = o_Done;
            w.t  = cyc;
            wq.push_back(w);
        end
    end

    task automatic tick();
        @(posedge i_Clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cmd(input logic op, input logic [9:0] a,
                       input logic [9:0] l, input logic [7:0] d);
        i_Cmd_Valid = 1'b1;
        i_Cmd_Op    = op;
        i_Cmd_Addr  = a;
        i_Cmd_Len   = l;
        i_Cmd_Data  = d;
    endtask

    initial begin
        logic [9:0] fill_a [4];
        int         rows[$];
        int         nxt;
        logic [18:0] bp_exp [6];
        int          bp_off [6];
        logic [31:0] e;
        logic [31:0] o;

        // reset state
        tick();
        check("rst_write", 32'(o_PF_Write), 32'd0);
        check("rst_addr",  32'(o_PF_Addr),  32'd0);
        check("rst_data",  32'(o_PF_Data),  32'd0);
        check("rst_done",  32'(o_Done),     32'd0);
        check("rst_busy",  32'(o_Busy),     32'd0);
        check("rst_ready", 32'(o_Cmd_Ready), 32'd1);
        i_Reset = 1'b0;
        tick();

        // single write
        cmd(1'b0, 10'h045, 10'd0, 8'h2A);
        tick();
        i_Cmd_Valid = 1'b0;
        check("sw_n_write", 32'(o_PF_Write), 32'd0);
        check("sw_n_busy",  32'(o_Busy),     32'd1);
        tick();
        check("sw_n1_write", 32'(o_PF_Write), 32'd0);
        tick();
        check("sw_n2_out", {12'd0, o_PF_Write, o_PF_Addr, o_PF_Data, o_Done},
              {12'd0, 1'b1, 10'h045, 8'h2A, 1'b1});
        tick();
        check("sw_after_busy",  32'(o_Busy),     32'd0);
        check("sw_after_write", 32'(o_PF_Write), 32'd0);
        check("sw_after_done",  32'(o_Done),     32'd0);

        // fill wrapping past the top of the address space
        i_Row = 10'd500;
        fill_a = '{10'h3FE, 10'h3FF, 10'h000, 10'h001};
        cmd(1'b1, 10'h3FE, 10'd3, 8'h07);
        tick();
        i_Cmd_Valid = 1'b0;
        tick();
        for (int i = 0; i < 4; i++) begin
            tick();
            check("fill_wrap", {12'd0, o_PF_Write, o_PF_Addr, o_PF_Data, o_Done},
                  {12'd0, 1'b1, fill_a[i], 8'h07, 1'(i == 3)});
        end
        tick();
        check("fill_end", {30'd0, o_PF_Write, o_Done}, 32'd0);

        // fill paused across the active region
        wq.delete();
        i_Row = 10'd519;
        cmd(1'b1, 10'h000, 10'd9, 8'h3C);
        tick();
        i_Cmd_Valid = 1'b0;
        i_Row = 10'd520;
        tick();
        for (int r = 521; r <= 524; r++) rows.push_back(r);
        for (int r = 0; r <= 7; r++) rows.push_back(r);
        for (int r = 478; r <= 490; r++) rows.push_back(r);
        nxt = 0;
        foreach (rows[k]) begin
            i_Row = 10'(rows[k]);
            tick();
            if (rows[k] >= 480 && nxt <= 9) begin
                e = {20'd0, 1'b1, 1'(nxt == 9), 10'(nxt)};
                nxt++;
            end else begin
                e = 32'd0;
            end
            o = {20'd0, o_PF_Write, o_Done, o_PF_Write ? o_PF_Addr : 10'd0};
            check("pause_step", o, e);
            if (rows[k] == 3) check("pause_busy", 32'(o_Busy), 32'd1);
        end
        check("pause_count", 32'(wq.size()), 32'd10);

        // backpressure and FIFO order
        wq.delete();
        i_Row = 10'd100;
        cmd(1'b0, 10'h100, 10'd0, 8'hA0);
        check("bp_ready_empty", 32'(o_Cmd_Ready), 32'd1);
        tick();
        cmd(1'b1, 10'h200, 10'd1, 8'hA1);
        tick();
        cmd(1'b0, 10'h300, 10'd0, 8'hA2);
        tick();
        cmd(1'b0, 10'h010, 10'd0, 8'hA3);
        tick();
        check("bp_ready_full", 32'(o_Cmd_Ready), 32'd0);
        cmd(1'b0, 10'h020, 10'd0, 8'hA4);
        tick();
        tick();
        check("bp_held_ready", 32'(o_Cmd_Ready), 32'd0);
        check("bp_held_busy",  32'(o_Busy),      32'd1);
        check("bp_no_write",   32'(wq.size()),   32'd0);
        i_Row = 10'd480;
        tick();
        check("bp_ready_after_pop", 32'(o_Cmd_Ready), 32'd1);
        tick();
        i_Cmd_Valid = 1'b0;
        for (int i = 0; i < 25; i++) tick();
        bp_exp = '{{10'h100, 8'hA0, 1'b1}, {10'h200, 8'hA1, 1'b0},
                   {10'h201, 8'hA1, 1'b1}, {10'h300, 8'hA2, 1'b1},
                   {10'h010, 8'hA3, 1'b1}, {10'h020, 8'hA4, 1'b1}};
        bp_off = '{0, 2, 3, 5, 7, 9};
        check("bp_count", 32'(wq.size()), 32'd6);
        for (int i = 0; i < 6 && i < wq.size(); i++) begin
            check("bp_order", {13'd0, wq[i].a, wq[i].d, wq[i].dn},
                  {13'd0, bp_exp[i]});
            check("bp_timing", 32'(wq[i].t - wq[0].t), 32'(bp_off[i]));
        end

        // reset in the middle of a fill with two commands queued
        cmd(1'b1, 10'h050, 10'd9, 8'h55);
        tick();
        cmd(1'b0, 10'h060, 10'd0, 8'h66);
        tick();
        cmd(1'b0, 10'h070, 10'd0, 8'h77);
        tick();
        i_Cmd_Valid = 1'b0;
        tick();
        tick();
        check("mid_write3", {21'd0, o_PF_Write, o_PF_Addr}, {21'd0, 1'b1, 10'h052});
        #2;
        i_Reset = 1'b1;
        #1;
        check("ar_write", 32'(o_PF_Write),  32'd0);
        check("ar_addr",  32'(o_PF_Addr),   32'd0);
        check("ar_data",  32'(o_PF_Data),   32'd0);
        check("ar_done",  32'(o_Done),      32'd0);
        check("ar_busy",  32'(o_Busy),      32'd0);
        check("ar_ready", 32'(o_Cmd_Ready), 32'd1);
        @(negedge i_Clk);
        i_Reset = 1'b0;
        wq.delete();
        for (int i = 0; i < 10; i++) tick();
        check("post_rst_writes", 32'(wq.size()),   32'd0);
        check("post_rst_busy",   32'(o_Busy),      32'd0);
        check("post_rst_ready",  32'(o_Cmd_Ready), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/playfield_writer.md
PLAYFIELD_WRITER -- requirements
Module: playfield_writer

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, setting the command FIFO depth in entries (power of two, 2..16).
REQ-002 SHALL have parameter V_ACTIVE, default 480, setting the first non-visible beam row.
REQ-003 SHALL have port i_Clk, input, 1 bit: the one clock; all state changes on its rising edge.
REQ-004 SHALL have port i_Reset, input, 1 bit: reset, asynchronous and active-high.
REQ-005 SHALL have port i_Row, input, 10 bits: current beam row from the VGA timing counter.
REQ-006 SHALL have port i_Cmd_Valid, input, 1 bit: command offered.
REQ-007 SHALL have port o_Cmd_Ready, output, 1 bit: command FIFO can accept.
REQ-008 SHALL have port i_Cmd_Op, input, 1 bit: 0 = single write, 1 = fill.
REQ-009 SHALL have port i_Cmd_Addr, input, 10 bits: playfield start address, {tile row[3:0], tile column[5:0]}.
REQ-010 SHALL have port i_Cmd_Len, input, 10 bits: fill count minus one (ignored for single write).
REQ-011 SHALL have port i_Cmd_Data, input, 8 bits: tile/sprite code to write.
REQ-012 SHALL have port o_PF_Write, output, 1 bit: write strobe to the playfield RAM write port.
REQ-013 SHALL have port o_PF_Addr, output, 10 bits: playfield RAM write address.
REQ-014 SHALL have port o_PF_Data, output, 8 bits: playfield RAM write data.
REQ-015 SHALL have port o_Busy, output, 1 bit: FIFO non-empty or command in progress.
REQ-016 SHALL have port o_Done, output, 1 bit: one-cycle pulse on each command's final write.

Function
REQ-017 SHALL accept a command on a rising edge where i_Cmd_Valid and o_Cmd_Ready are both 1, storing {op, addr, len, data} at the FIFO tail.
REQ-018 SHALL drive o_Cmd_Ready = 1 exactly when FIFO occupancy < FIFO_DEPTH (combinational from occupancy; no push-when-full bypass).
REQ-019 SHALL treat blanking as i_Row >= V_ACTIVE; playfield writes occur only during blanking.
REQ-020 SHALL implement states IDLE and EXEC.
REQ-021 IDLE: when FIFO non-empty and blanking, SHALL pop the head on that edge, load the current address, data, and remaining count (0 for single, len for fill), and enter EXEC.
REQ-022 EXEC with blanking SHALL, on each edge, register o_PF_Write = 1, o_PF_Addr = current address, o_PF_Data = data, then increment the address modulo 1024.
REQ-023 EXEC: when remaining count is 0 at that edge, SHALL also register o_Done = 1 and return to IDLE; otherwise SHALL decrement the count.
REQ-024 EXEC without blanking SHALL hold all state, register o_PF_Write = 0, and resume at the next blanking row without skipping or repeating an address.
REQ-025 Latency: a command accepted at edge N into an empty FIFO while IDLE and blanking SHALL produce its first o_PF_Write = 1 after edge N+2.
REQ-026 Throughput: a fill of len L SHALL issue L+1 consecutive writes (one per cycle while blanking); len 1023 covers all 1024 entries exactly once.
REQ-027 Back-to-back commands SHALL cost one idle cycle between the final write of one and the first write of the next.
REQ-028 A simultaneous push and pop SHALL leave occupancy unchanged and preserve FIFO order.
REQ-029 o_PF_Write, o_PF_Addr, o_PF_Data, and o_Done SHALL be registered; o_Done SHALL be 0 on every cycle other than a final write.
REQ-030 o_Busy SHALL equal (occupancy != 0) OR (state == EXEC).

Reset
REQ-031 On i_Reset = 1, SHALL immediately set state IDLE, occupancy 0, o_PF_Write 0, o_PF_Addr 0, o_PF_Data 0, o_Done 0 (o_Busy 0, o_Cmd_Ready 1).
REQ-032 Reset mid-fill SHALL abandon the command and all queued commands with no further writes; already-written playfield entries are unaffected.

Verification
REQ-033 Single write: i_Row=480, push op=0 addr=0x045 data=0x2A at edge N -> o_PF_Write=1, addr 0x045, data 0x2A after edge N+2, o_Done=1 same cycle, o_Busy=0 next cycle.
REQ-034 Fill wrap: i_Row=500, push op=1 addr=0x3FE len=3 data=0x07 -> four writes to 0x3FE, 0x3FF, 0x000, 0x001; o_Done only on 0x001.
REQ-035 Blank pause: fill addr=0 len=9 starting 4 cycles before i_Row goes 524->0 -> 4 writes (0..3), none during rows 0..479, then addresses 4..9 from row 480; no gaps or repeats.
REQ-036 Backpressure: i_Row=100, push 5 commands with FIFO_DEPTH=4 -> o_Cmd_Ready=0 after the 4th, 5th held; at blanking all 5 execute in push order.
REQ-037 Reset mid-op: assert i_Reset during write 3 of a len=9 fill with 2 queued -> outputs 0 asynchronously, no writes after release, o_Busy=0, o_Cmd_Ready=1.
